awg_param_scheduler: RTL and testbench

Commit controller between the UART command decoder and the waveform datapath. Stages waveform-select, phase-increment and amplitude writes in shadow registers and applies them atomically on a phase-accumulator wrap, so the generator never switches mid-period. Then hands any changed amplitude to the I2C amplitude transmitter over a req/ack handshake. Runs in the generator clock domain; command inputs arrive already synchronised.

---
 rtl/awg_pkg.sv | 22 ++
 rtl/awg_wrap_timer.sv | 29 ++
 rtl/awg_param_scheduler.sv | 122 ++++++++++++
 tb/tb_awg_param_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/awg_pkg.sv
// rtl/awg_pkg.sv - shared constants and state type for the AWG parameter scheduler
package awg_pkg;

   localparam int AWG_DATA_W = 32;
   localparam int AWG_SEL_W  = 8;

   localparam logic [1:0] AWG_ADDR_SEL    = 2'd0;
   localparam logic [1:0] AWG_ADDR_ADDER  = 2'd1;
   localparam logic [1:0] AWG_ADDR_AMP    = 2'd2;
   localparam logic [1:0] AWG_ADDR_COMMIT = 2'd3;

   localparam int DIRTY_SEL   = 0;
   localparam int DIRTY_ADDER = 1;
   localparam int DIRTY_AMP   = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_AMP_REQ = 2'd2
   } sched_state_t;

endpackage

// File: rtl/awg_wrap_timer.sv
// rtl/awg_wrap_timer.sv - ARMED-state timeout counter, used only with AWG_SCHED_WRAP_TIMEOUT_EN
module awg_wrap_timer #(
   parameter int LIMIT = 1048576
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CNT_W-1:0] count;

   // expire lands on the LIMIT-th enabled cycle after the last clear
   assign expire = enable && (count == CNT_W'(LIMIT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expire) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/awg_param_scheduler.sv
// rtl/awg_param_scheduler.sv - shadowed waveform parameters committed on phase wrap, amplitude handed to I2C
// Optional forced commit after WRAP_TIMEOUT cycles in ARMED: AWG_SCHED_WRAP_TIMEOUT_EN
module awg_param_scheduler
   import awg_pkg::*;
#(
   parameter int DATA_W       = AWG_DATA_W,
   parameter int SEL_W        = AWG_SEL_W,
   parameter int WRAP_TIMEOUT = 1048576
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic              phase_wrap,
   output logic [SEL_W-1:0]  signal_number,
   output logic [DATA_W-1:0] adder,
   output logic              amp_req,
   output logic [DATA_W-1:0] amp_data,
   input  logic              amp_ack,
   output logic              busy,
   output logic              commit_done
);

   sched_state_t      state, state_nxt;
   logic [SEL_W-1:0]  sh_sel;
   logic [DATA_W-1:0] sh_adder;
   logic [DATA_W-1:0] sh_amp;
   logic [2:0]        dirty;
   logic              cmd_fire, wr_shadow, wr_commit, apply;

   // Status outputs decode straight from state so reset drops them without a clock
   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign amp_req   = (state == ST_AMP_REQ);

   assign cmd_fire  = cmd_valid && cmd_ready;
   assign wr_shadow = cmd_fire && (cmd_addr != AWG_ADDR_COMMIT);
   assign wr_commit = cmd_fire && (cmd_addr == AWG_ADDR_COMMIT);

`ifdef AWG_SCHED_WRAP_TIMEOUT_EN
   logic timeout;

   awg_wrap_timer #(
      .LIMIT (WRAP_TIMEOUT)
   ) u_wrap_timer (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (state != ST_ARMED),
      .enable (state == ST_ARMED),
      .expire (timeout)
   );

   assign apply = (state == ST_ARMED) && (phase_wrap || timeout);
`else
   logic unused_wrap_timeout;
   assign unused_wrap_timeout = ^WRAP_TIMEOUT;
   assign apply = (state == ST_ARMED) && phase_wrap;
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (wr_commit && (dirty != '0)) state_nxt = ST_ARMED;
         end
         ST_ARMED: begin
            if (apply) state_nxt = dirty[DIRTY_AMP] ? ST_AMP_REQ : ST_IDLE;
         end
         ST_AMP_REQ: begin
            if (amp_ack) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         sh_sel        <= '0;
         sh_adder      <= '0;
         sh_amp        <= '0;
         dirty         <= '0;
         signal_number <= '0;
         adder         <= '0;
         amp_data      <= '0;
         commit_done   <= 1'b0;
      end else begin
         state       <= state_nxt;
         commit_done <= (wr_commit && (dirty == '0))
                     || (apply && !dirty[DIRTY_AMP])
                     || (amp_req && amp_ack);

         if (wr_shadow) begin
            case (cmd_addr)
               AWG_ADDR_SEL: begin
                  sh_sel             <= cmd_data[SEL_W-1:0];
                  dirty[DIRTY_SEL]   <= 1'b1;
               end
               AWG_ADDR_ADDER: begin
                  sh_adder           <= cmd_data;
                  dirty[DIRTY_ADDER] <= 1'b1;
               end
               default: begin
                  sh_amp             <= cmd_data;
                  dirty[DIRTY_AMP]   <= 1'b1;
               end
            endcase
         end

         // Shadows are only writable in IDLE, so apply never collides with a shadow write
         if (apply) begin
            signal_number <= sh_sel;
            adder         <= sh_adder;
            amp_data      <= sh_amp;
            dirty         <= '0;
         end
      end
   end

endmodule

// File: tb/tb_awg_param_scheduler.sv
// tb/tb_awg_param_scheduler.sv - self-checking bench for awg_param_scheduler
module tb_awg_param_scheduler;

   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_addr = 2'd0;
   logic [31:0] cmd_data = 32'd0;
   logic        phase_wrap = 1'b0;
   logic [7:0]  signal_number;
   logic [31:0] adder;
   logic        amp_req;
   logic [31:0] amp_data;
   logic        amp_ack = 1'b0;
   logic        busy;
   logic        commit_done;

   int checks = 0;
   int errors = 0;

   // reference model: active values, pending values, pending flags
   logic [7:0]  m_sel = 8'd0, p_sel = 8'd0;
   logic [31:0] m_adder = 32'd0, p_adder = 32'd0;
   logic [31:0] m_amp = 32'd0, p_amp = 32'd0;
   bit          d_sel = 0, d_adder = 0, d_amp = 0;

   awg_param_scheduler #(
      .DATA_W      (32),
      .SEL_W       (8),
      .WRAP_TIMEOUT(TMO)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_addr     (cmd_addr),
      .cmd_data     (cmd_data),
      .phase_wrap   (phase_wrap),
      .signal_number(signal_number),
      .adder        (adder),
      .amp_req      (amp_req),
      .amp_data     (amp_data),
      .amp_ack      (amp_ack),
      .busy         (busy),
      .commit_done  (commit_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_apply();
      m_sel   = p_sel;
      m_adder = p_adder;
      m_amp   = p_amp;
   endtask

   task automatic do_write(logic [1:0] a, logic [31:0] d);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_data  = d;
      #1;
      check("wr_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      case (a)
         2'd0: begin p_sel = d[7:0]; d_sel = 1; end
         2'd1: begin p_adder = d; d_adder = 1; end
         default: begin p_amp = d; d_amp = 1; end
      endcase
   endtask

   task automatic issue_commit(bit wrap_too);
      cmd_valid  = 1'b1;
      cmd_addr   = 2'd3;
      cmd_data   = 32'd0;
      phase_wrap = wrap_too;
      #1;
      check("commit_ready", cmd_ready, 1);
      tick();
      cmd_valid  = 1'b0;
      phase_wrap = 1'b0;
   endtask

   task automatic do_commit(int wrap_delay, int ack_delay, bit wrap_too, bit hold_cmd);
      bit any;
      bit held;
      any = d_sel || d_adder || d_amp;
      issue_commit(wrap_too);
      if (!any) begin
         check("empty_done", commit_done, 1);
         check("empty_busy", busy, 0);
         check("empty_sel", signal_number, m_sel);
         check("empty_adder", adder, m_adder);
         tick();
         check("empty_done_pulse", commit_done, 0);
         return;
      end
      check("armed_busy", busy, 1);
      check("armed_ready", cmd_ready, 0);
      check("armed_req", amp_req, 0);
      check("armed_adder", adder, m_adder);
      if (hold_cmd) begin
         cmd_valid = 1'b1;
         cmd_addr  = 2'd0;
         cmd_data  = 32'h5A;
      end
      held = 1;
      repeat (wrap_delay) begin
         tick();
         held = held && busy === 1'b1 && cmd_ready === 1'b0 && commit_done === 1'b0
                && amp_req === 1'b0 && adder === m_adder && signal_number === m_sel;
      end
      check("armed_hold", held, 1);
      phase_wrap = 1'b1;
      tick();
      phase_wrap = 1'b0;
      model_apply();
      check("apply_sel", signal_number, m_sel);
      check("apply_adder", adder, m_adder);
      if (d_amp) begin
         check("amp_req_rise", amp_req, 1);
         check("amp_data", amp_data, m_amp);
         check("amp_ready", cmd_ready, 0);
         check("amp_done_early", commit_done, 0);
         held = 1;
         repeat (ack_delay) begin
            tick();
            held = held && amp_req === 1'b1 && cmd_ready === 1'b0 && busy === 1'b1
                   && amp_data === m_amp && commit_done === 1'b0;
         end
         check("amp_hold", held, 1);
         amp_ack = 1'b1;
         tick();
         amp_ack = 1'b0;
         check("ack_req_low", amp_req, 0);
         check("ack_done", commit_done, 1);
         check("ack_ready", cmd_ready, 1);
      end else begin
         check("noamp_done", commit_done, 1);
         check("noamp_ready", cmd_ready, 1);
         check("noamp_req", amp_req, 0);
         check("noamp_data", amp_data, m_amp);
      end
      d_sel = 0; d_adder = 0; d_amp = 0;
      tick();
      check("done_pulse", commit_done, 0);
      if (hold_cmd) begin
         cmd_valid = 1'b0;
         p_sel = 8'h5A;
         d_sel = 1;
      end
   endtask

   initial begin
      int n;
      tick();
      tick();
      check("rst_sel", signal_number, 0);
      check("rst_adder", adder, 0);
      check("rst_amp_data", amp_data, 0);
      check("rst_amp_req", amp_req, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", commit_done, 0);
      reset_n = 1'b1;
      tick();

      do_write(2'd0, 32'd3);
      do_write(2'd1, 32'h0100_0000);
      do_commit(19, 0, 0, 0);
      check("t1_sel", signal_number, 3);
      check("t1_adder", adder, 32'h0100_0000);

      do_write(2'd2, 32'h8000_0000);
      do_commit(3, 50, 0, 0);

      do_commit(0, 0, 0, 0);

      do_write(2'd0, 32'd7);
      do_commit(2, 0, 1, 0);

      do_write(2'd1, 32'd5);
      do_write(2'd1, 32'd9);
      do_commit(4, 0, 0, 1);
      check("t4_adder", adder, 9);
      do_commit(1, 0, 0, 0);
      check("t4_held_sel", signal_number, 8'h5A);

      do_write(2'd2, m_amp);
      do_commit(1, 2, 0, 0);

      do_write(2'd1, 32'd0);
      issue_commit(0);
`ifdef AWG_SCHED_WRAP_TIMEOUT_EN
      repeat (TMO - 1) tick();
      check("tmo_still_armed", busy, 1);
      check("tmo_adder_old", adder, m_adder);
      tick();
      model_apply();
      check("tmo_adder_new", adder, 0);
      check("tmo_done", commit_done, 1);
      check("tmo_busy", busy, 0);
`else
      repeat (1000) tick();
      check("notmo_busy", busy, 1);
      check("notmo_adder_old", adder, m_adder);
      phase_wrap = 1'b1;
      tick();
      phase_wrap = 1'b0;
      model_apply();
      check("notmo_adder_new", adder, 0);
      check("notmo_done", commit_done, 1);
`endif
      d_sel = 0; d_adder = 0; d_amp = 0;
      tick();

      do_write(2'd0, 32'd12);
      do_write(2'd1, 32'h40);
      do_write(2'd2, 32'h1234);
      issue_commit(0);
      phase_wrap = 1'b1;
      tick();
      phase_wrap = 1'b0;
      check("rst_pre_req", amp_req, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_req", amp_req, 0);
      check("arst_busy", busy, 0);
      check("arst_sel", signal_number, 0);
      check("arst_adder", adder, 0);
      check("arst_amp_data", amp_data, 0);
      m_sel = 0; m_adder = 0; m_amp = 0;
      p_sel = 0; p_adder = 0; p_amp = 0;
      d_sel = 0; d_adder = 0; d_amp = 0;
      tick();
      reset_n = 1'b1;
      tick();
      check("rel_ready", cmd_ready, 1);
      check("rel_busy", busy, 0);

      for (int it = 0; it < 12; it++) begin
         n = $urandom_range(0, 3);
         for (int k = 0; k < n; k++) begin
            do_write(2'($urandom_range(0, 2)), $urandom());
         end
         do_commit($urandom_range(0, 8), $urandom_range(0, 4), 1'($urandom_range(0, 1)), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
